// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx byte transmitter between two byte-stream requesters.
//   Once a requester wins, it keeps the transmitter until its last byte has
//   shifted out. Packets therefore never interleave. An optional idle timeout
//   frees the transmitter if the owner stalls in the middle of a packet.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | no owner; arbitrate between valid requesters (round robin)
//   LOCKED    | owner mid-packet, waiting for its next byte; idle counter runs
//   SEND      | byte latched; start_o pulses to uart_tx this cycle
//   WAIT_DONE | byte shifting out; wait for done_i
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   reqN_data_i/valid_i/last_i/ready_o
//                            byte stream from requester N (0 bridge, 1 events)
//   data_o, start_o          byte and one-cycle start pulse to uart_tx
//   done_i                   one-cycle pulse from uart_tx when the byte is out
//   grant_o                  current owner index, meaningful while busy_o
//   busy_o                   high whenever not IDLE
//   timeout_o                one-cycle pulse when a stalled owner is evicted
//
// Parameter
//   LOCK_TIMEOUT             idle clocks tolerated in LOCKED; 0 = never evict

module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data_i,
  input  logic       req0_valid_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic [7:0] req1_data_i,
  input  logic       req1_valid_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  output logic [7:0] data_o,
  output logic       start_o,
  input  logic       done_i,
  output logic       grant_o,
  output logic       busy_o,
  output logic       timeout_o
);

  // With the timeout disabled the counter is still kept one bit wide so the
  // datapath stays legal. It simply saturates and is never compared.
  localparam int unsigned     CNT_W      = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit              TIMEOUT_EN = (LOCK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_SEND,
    ST_WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic             xfer0, xfer1, xfer;
  logic [7:0]       sel_data;
  logic             sel_last;

  // Ready is combinational on valid in IDLE. When both requesters are valid,
  // the round-robin pointer decides between them. In LOCKED only the owner
  // may move, whatever the other side is doing.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready_o = req0_valid_i && (!req1_valid_i || !rr_q);
        req1_ready_o = req1_valid_i && (!req0_valid_i ||  rr_q);
      end
      ST_LOCKED: begin
        req0_ready_o = !grant_q;
        req1_ready_o =  grant_q;
      end
      default: begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
      end
    endcase
  end

  assign xfer0    = req0_valid_i && req0_ready_o;
  assign xfer1    = req1_valid_i && req1_ready_o;
  assign xfer     = xfer0 || xfer1;
  assign sel_data = xfer1 ? req1_data_i : req0_data_i;
  assign sel_last = xfer1 ? req1_last_i : req0_last_i;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    start_o    = 1'b0;
    timeout_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          grant_d = xfer1;
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = ST_SEND;
        end
      end

      ST_LOCKED: begin
        // A byte arriving on the timeout cycle is still accepted.
        if (xfer) begin
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = ST_SEND;
        end else if (TIMEOUT_EN && (idle_cnt_q == CNT_LIMIT)) begin
          timeout_o = 1'b1;
          rr_d      = !grant_q;
          state_d   = ST_IDLE;
        end else if (idle_cnt_q != CNT_MAX) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      ST_SEND: begin
        start_o = 1'b1;
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (done_i) begin
          if (last_q) begin
            rr_d    = !grant_q;
            state_d = ST_IDLE;
          end else begin
            idle_cnt_d = '0;
            state_d    = ST_LOCKED;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      grant_q    <= 1'b0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      last_q     <= last_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed scenarios followed by a randomized two-requester run. A packet-
//   ownership reference model predicts ready/start/busy/grant/timeout and the
//   byte order. A behavioural uart_tx stand-in returns done_i a random number
//   of clocks after each start_o.

module tb_uart_tx_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data_i = 8'h00, req1_data_i = 8'h00;
  logic       req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic       req0_last_i = 1'b0, req1_last_i = 1'b0;
  logic       req0_ready_o, req1_ready_o;
  logic [7:0] data_o;
  logic       start_o;
  logic       done_i = 1'b0;
  logic       grant_o, busy_o, timeout_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.LOCK_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_data_i  (req0_data_i),
    .req0_valid_i (req0_valid_i),
    .req0_last_i  (req0_last_i),
    .req0_ready_o (req0_ready_o),
    .req1_data_i  (req1_data_i),
    .req1_valid_i (req1_valid_i),
    .req1_last_i  (req1_last_i),
    .req1_ready_o (req1_ready_o),
    .data_o       (data_o),
    .start_o      (start_o),
    .done_i       (done_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  // stimulus state
  bit         rst_v = 1'b1;
  bit         v [2];
  logic [7:0] d [2];
  bit         l [2];
  bit         x [2];
  bit         force_done = 1'b0;
  int         resp_cnt = 0, resp_min = 1, resp_max = 4;
  int         cyc = 0, last_done_cyc = -1, to_cyc = -1;
  int         total = 0, bad = 0;

  // reference model: who owns the transmitter, is a byte in flight
  int         m_owner = -1;
  bit         m_rr = 1'b0, m_inflight = 1'b0, m_last = 1'b0, m_start_due = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_idle = 0;

  logic [7:0] q_sent [$];
  logic [7:0] q_by [2][$];
  logic [7:0] gen_d [2][$];
  bit         gen_l [2][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit e_r0, e_r1, e_to, e_start, e_busy, done_v;
    @(negedge clk);
    rst          = rst_v;
    req0_valid_i = v[0]; req0_data_i = d[0]; req0_last_i = l[0];
    req1_valid_i = v[1]; req1_data_i = d[1]; req1_last_i = l[1];
    done_v       = (resp_cnt == 1) || force_done;
    done_i       = done_v;
    #1;
    cyc++;
    if (done_v) last_done_cyc = cyc;

    e_start = m_start_due;
    e_busy  = (m_owner >= 0);
    if (m_owner < 0) begin
      e_r0 = v[0] && (!v[1] || !m_rr);
      e_r1 = v[1] && (!v[0] ||  m_rr);
    end else if (m_inflight) begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
    end else begin
      e_r0 = (m_owner == 0);
      e_r1 = (m_owner == 1);
    end
    x[0] = v[0] && e_r0 && !rst_v;
    x[1] = v[1] && e_r1 && !rst_v;
    e_to = (m_owner >= 0) && !m_inflight && (m_idle == T) && !(x[0] || x[1]);

    check("start", start_o, e_start);
    check("busy", busy_o, e_busy);
    check("ready0", req0_ready_o, e_r0);
    check("ready1", req1_ready_o, e_r1);
    check("timeout", timeout_o, e_to);
    if (e_busy) check("grant", grant_o, (m_owner == 1));
    if (e_start) check("data", data_o, m_byte);

    if (start_o === 1'b1) begin
      q_sent.push_back(data_o);
      if (m_owner >= 0) q_by[m_owner].push_back(data_o);
      resp_cnt = $urandom_range(resp_max, resp_min);
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end
    if (timeout_o === 1'b1) to_cyc = cyc;

    if (rst_v) begin
      m_owner = -1; m_rr = 1'b0; m_inflight = 1'b0; m_last = 1'b0;
      m_start_due = 1'b0; m_idle = 0; m_byte = 8'h00;
    end else begin
      m_start_due = 1'b0;
      if (m_owner < 0 || !m_inflight) begin
        if ((m_owner < 0 && (x[0] || x[1])) || (m_owner >= 0 && x[m_owner])) begin
          if (m_owner < 0) m_owner = x[1] ? 1 : 0;
          m_inflight  = 1'b1;
          m_start_due = 1'b1;
          m_byte      = x[1] ? d[1] : d[0];
          m_last      = x[1] ? l[1] : l[0];
        end else if (m_owner >= 0) begin
          if (e_to) begin
            m_rr    = (m_owner == 0);
            m_owner = -1;
          end else begin
            m_idle++;
          end
        end
      end else if (!e_start && done_v) begin
        m_inflight = 1'b0;
        if (m_last) begin
          m_rr    = (m_owner == 0);
          m_owner = -1;
        end else begin
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic send_byte(input int n, input logic [7:0] b, input bit lst);
    bit got = 1'b0;
    v[n] = 1'b1; d[n] = b; l[n] = lst;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = x[n];
    end
    v[n] = 1'b0;
    check($sformatf("accept%0d_%02h", n, b), got, 1);
  endtask

  task automatic run_both(input logic [7:0] b0, input logic [7:0] b1);
    bit g0 = 1'b0, g1 = 1'b0;
    v[0] = 1'b1; d[0] = b0; l[0] = 1'b1;
    v[1] = 1'b1; d[1] = b1; l[1] = 1'b1;
    for (int k = 0; k < 60 && !(g0 && g1); k++) begin
      step();
      if (x[0]) begin g0 = 1'b1; v[0] = 1'b0; end
      if (x[1]) begin g1 = 1'b1; v[1] = 1'b0; end
    end
    check("both_accept0", g0, 1);
    check("both_accept1", g1, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (m_owner >= 0 || m_inflight); k++) step();
    step();
    check("drain_busy", busy_o, 0);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0]  e [4];
    logic [31:0] obs;
    e = '{b0, b1, b2, b3};
    check({tag, "_len"}, q_sent.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (i < q_sent.size()) ? {24'h0, q_sent[i]} : 32'hxxxx_xxxx;
      check($sformatf("%s_%0d", tag, i), obs, {24'h0, e[i]});
    end
  endtask

  initial begin
    int ptr [2];
    int gap [2];
    int len;
    logic [31:0] obs;

    v[0] = 1'b0; v[1] = 1'b0; d[0] = 8'h00; d[1] = 8'h00; l[0] = 1'b0; l[1] = 1'b0;

    // reset values
    rst_v = 1'b1;
    repeat (3) step();
    rst_v = 1'b0;
    step();
    check("rst_data", data_o, 8'h00);
    check("rst_grant", grant_o, 0);

    // two-byte packet from req0
    q_sent.delete();
    send_byte(0, 8'h41, 1'b0);
    send_byte(0, 8'h42, 1'b1);
    drain();
    check_seq("pkt", 2, 8'h41, 8'h42, 8'h00, 8'h00);

    // contention straight after reset: req0 first, pointer back at 0
    rst_v = 1'b1; step(); rst_v = 1'b0;
    q_sent.delete();
    run_both(8'hAA, 8'h55);
    drain();
    check_seq("cont", 2, 8'hAA, 8'h55, 8'h00, 8'h00);
    v[0] = 1'b1; d[0] = 8'hC0; l[0] = 1'b1;
    v[1] = 1'b1; d[1] = 8'hC1; l[1] = 1'b1;
    step();
    check("rr_ready0", req0_ready_o, 1);
    check("rr_ready1", req1_ready_o, 0);
    v[0] = 1'b0;
    send_byte(1, 8'hC1, 1'b1);
    drain();

    // atomicity: req0 waits behind a three-byte req1 packet
    q_sent.delete();
    send_byte(1, 8'h01, 1'b0);
    v[0] = 1'b1; d[0] = 8'h77; l[0] = 1'b1;
    send_byte(1, 8'h02, 1'b0);
    send_byte(1, 8'h03, 1'b1);
    send_byte(0, 8'h77, 1'b1);
    drain();
    check_seq("atom", 4, 8'h01, 8'h02, 8'h03, 8'h77);

    // lock timeout: req0 stalls mid-packet, req1 takes over
    q_sent.delete();
    to_cyc = -1;
    send_byte(0, 8'h10, 1'b0);
    v[1] = 1'b1; d[1] = 8'h66; l[1] = 1'b1;
    for (int k = 0; k < 40 && to_cyc < 0; k++) step();
    check("to_seen", (to_cyc >= 0), 1);
    check("to_delay", to_cyc - last_done_cyc, T + 1);
    send_byte(1, 8'h66, 1'b1);
    drain();
    check_seq("tmo", 2, 8'h10, 8'h66, 8'h00, 8'h00);

    // reset during WAIT_DONE, then stray done pulses
    resp_min = 6; resp_max = 6;
    q_sent.delete();
    send_byte(0, 8'h21, 1'b0);
    step();
    step();
    rst_v = 1'b1; step(); rst_v = 1'b0;
    force_done = 1'b1; step(); force_done = 1'b0;
    check("rst_mid_busy", busy_o, 0);
    repeat (8) step();
    check("rst_nostart", q_sent.size(), 1);
    resp_min = 1; resp_max = 4;
    run_both(8'h31, 8'h32);
    drain();
    check_seq("rstpkt", 3, 8'h21, 8'h31, 8'h32, 8'h00);

    // randomized traffic with stalls long enough to trip the timeout
    for (int n = 0; n < 2; n++) begin
      q_by[n].delete();
      for (int p = 0; p < 20; p++) begin
        len = $urandom_range(3, 1);
        for (int b = 0; b < len; b++) begin
          gen_d[n].push_back(8'($urandom_range(255, 0)));
          gen_l[n].push_back(b == len - 1);
        end
      end
      ptr[n] = 0;
      gap[n] = 0;
    end
    for (int c = 0; c < 8000 &&
         !(ptr[0] == gen_d[0].size() && ptr[1] == gen_d[1].size() &&
           m_owner < 0 && !m_inflight); c++) begin
      for (int n = 0; n < 2; n++) begin
        if (ptr[n] < gen_d[n].size() && gap[n] == 0) begin
          v[n] = 1'b1; d[n] = gen_d[n][ptr[n]]; l[n] = gen_l[n][ptr[n]];
        end else begin
          v[n] = 1'b0;
        end
      end
      force_done = !m_inflight && ($urandom_range(15, 0) == 0);
      step();
      force_done = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (x[n]) begin
          ptr[n]++;
          gap[n] = ($urandom_range(4, 0) == 0) ? $urandom_range(12, 8) : $urandom_range(1, 0);
        end else if (gap[n] > 0) begin
          gap[n]--;
        end
      end
    end
    v[0] = 1'b0; v[1] = 1'b0;
    drain();
    for (int n = 0; n < 2; n++) begin
      check($sformatf("rand_len%0d", n), q_by[n].size(), gen_d[n].size());
      for (int i = 0; i < gen_d[n].size(); i++) begin
        obs = (i < q_by[n].size()) ? {24'h0, q_by[n][i]} : 32'hxxxx_xxxx;
        check($sformatf("rand_byte%0d_%0d", n, i), obs, {24'h0, gen_d[n][i]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
